// File: rtl/alu_sweep_driver.sv
// ALU sweep engine: latches one operand pair, steps the ALU through op codes 0..MAX_OP,
// and compacts every settled response into a 32-bit MISR signature plus flag counters.
module alu_sweep_driver #(
    parameter logic [3:0]  MAX_OP        = 4'd10,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SIG_SEED      = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic        alu_overflow,
    input  logic        alu_equal,
    input  logic        alu_zero,
    output logic [31:0] signature,
    output logic [3:0]  zero_count,
    output logic [3:0]  ovf_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] settle_cnt;
    logic          accept;
    logic          capture;
    logic          feedback;
    logic [31:0]   misr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = CAPTURE;
            CAPTURE: state_next = (alu_op == MAX_OP) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state == SETTLE) || (state == CAPTURE);
    assign done    = (state == DONE);
    assign accept  = (state == IDLE) && start;
    assign capture = (state == CAPTURE);

    // Taps for x^32+x^22+x^2+x+1; the ALU word and flags fold in after the shift.
    assign feedback  = signature[31] ^ signature[21] ^ signature[1] ^ signature[0];
    assign misr_next = {signature[30:0], feedback} ^ alu_z
                     ^ {29'b0, alu_overflow, alu_equal, alu_zero};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_x      <= '0;
            alu_y      <= '0;
            alu_op     <= '0;
            signature  <= SIG_SEED;
            zero_count <= '0;
            ovf_count  <= '0;
            settle_cnt <= '0;
        end else if (accept) begin
            alu_x      <= x_in;
            alu_y      <= y_in;
            alu_op     <= '0;
            signature  <= SIG_SEED;
            zero_count <= '0;
            ovf_count  <= '0;
            settle_cnt <= SETTLE_RELOAD;
        end else if (state == SETTLE) begin
            if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end else if (capture) begin
            signature <= misr_next;
            if (alu_zero && (zero_count != 4'hF)) begin
                zero_count <= zero_count + 4'd1;
            end
            if (alu_overflow && (ovf_count != 4'hF)) begin
                ovf_count <= ovf_count + 4'd1;
            end
            // Op code stays on MAX_OP after the final capture so the last response is visible.
            if (alu_op != MAX_OP) begin
                alu_op     <= alu_op + 4'd1;
                settle_cnt <= SETTLE_RELOAD;
            end
        end
    end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Self-checking bench for alu_sweep_driver: two instances (SETTLE_CYCLES=1 and 3) behind an
// ALU stub, checked cycle-by-cycle against a sweep-level timing and signature model.
module tb_alu_sweep_driver;

    localparam int          MAX_OP = 10;
    localparam logic [31:0] SEED   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_req = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;

    logic        start_a, busy_a, done_a, ovf_a, eq_a, zero_a;
    logic [31:0] ax_a, ay_a, z_a, sig_a;
    logic [3:0]  op_a, zc_a, oc_a;
    logic        start_b, busy_b, done_b, ovf_b, eq_b, zero_b;
    logic [31:0] ax_b, ay_b, z_b, sig_b;
    logic [3:0]  op_b, zc_b, oc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign start_a = start_req & ~sel;
    assign start_b = start_req & sel;

    // ALU stub shared by both instances.
    assign z_a    = ax_a ^ {28'b0, op_a};
    assign zero_a = (z_a == 32'd0);
    assign ovf_a  = op_a[0];
    assign eq_a   = (ax_a == ay_a);
    assign z_b    = ax_b ^ {28'b0, op_b};
    assign zero_b = (z_b == 32'd0);
    assign ovf_b  = op_b[0];
    assign eq_b   = (ax_b == ay_b);

    alu_sweep_driver #(.MAX_OP(4'd10), .SETTLE_CYCLES(1), .SIG_SEED(32'hFFFFFFFF)) dut (
        .clk(clk), .rst(rst), .start(start_a), .x_in(x_in), .y_in(y_in),
        .busy(busy_a), .done(done_a), .alu_x(ax_a), .alu_y(ay_a), .alu_op(op_a),
        .alu_z(z_a), .alu_overflow(ovf_a), .alu_equal(eq_a), .alu_zero(zero_a),
        .signature(sig_a), .zero_count(zc_a), .ovf_count(oc_a)
    );

    alu_sweep_driver #(.MAX_OP(4'd10), .SETTLE_CYCLES(3), .SIG_SEED(32'hFFFFFFFF)) dut3 (
        .clk(clk), .rst(rst), .start(start_b), .x_in(x_in), .y_in(y_in),
        .busy(busy_b), .done(done_b), .alu_x(ax_b), .alu_y(ay_b), .alu_op(op_b),
        .alu_z(z_b), .alu_overflow(ovf_b), .alu_equal(eq_b), .alu_zero(zero_b),
        .signature(sig_b), .zero_count(zc_b), .ovf_count(oc_b)
    );

    wire        m_busy = sel ? busy_b : busy_a;
    wire        m_done = sel ? done_b : done_a;
    wire [3:0]  m_op   = sel ? op_b : op_a;
    wire [31:0] m_x    = sel ? ax_b : ax_a;
    wire [31:0] m_y    = sel ? ay_b : ay_a;
    wire [31:0] m_sig  = sel ? sig_b : sig_a;
    wire [3:0]  m_zc   = sel ? zc_b : zc_a;
    wire [3:0]  m_oc   = sel ? oc_b : oc_a;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-sweep reference: run the stub ALU over every op code and fold it into the MISR.
    function automatic void sweepModel(input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] sig, output int zc, output int oc);
        logic [31:0] z;
        logic        fb;
        logic        eq;
        sig = SEED;
        zc  = 0;
        oc  = 0;
        eq  = (x == y);
        for (int op = 0; op <= MAX_OP; op++) begin
            z  = x ^ 32'(op);
            fb = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
            sig = {sig[30:0], fb} ^ z ^ {29'b0, 1'(op % 2), eq, (z == 32'd0)};
            if (z == 32'd0) zc++;
            if (op % 2 == 1) oc++;
        end
    endfunction

    // Launches nsweeps sweeps on the selected instance and checks every cycle. With hold set,
    // start stays high so each new sweep must begin only on the IDLE cycle after done.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input bit use3,
                                 input bit hold, input int nsweeps);
        int          s;
        int          len;
        int          period;
        int          last;
        int          m;
        int          dones;
        int          ezc;
        int          eoc;
        logic [31:0] esig;
        s      = use3 ? 3 : 1;
        len    = (MAX_OP + 1) * (s + 1);
        period = len + 2;
        last   = (nsweeps - 1) * period + len;
        dones  = 0;
        sweepModel(x, y, esig, ezc, eoc);
        @(negedge clk);
        sel       = use3;
        x_in      = x;
        y_in      = y;
        start_req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_req = 1'b0;
        for (int n = 0; n <= last; n++) begin
            m = n % period;
            checkOutput("op", {28'b0, m_op}, (m < len) ? 32'(m / (s + 1)) : 32'(MAX_OP));
            checkOutput("busy", {31'b0, m_busy}, {31'b0, (m < len)});
            checkOutput("done", {31'b0, m_done}, {31'b0, (m == len)});
            checkOutput("alu_x", m_x, x);
            checkOutput("alu_y", m_y, y);
            if (m_done) dones++;
            if (m == 0) begin
                checkOutput("sig_seeded", m_sig, SEED);
                checkOutput("zc_cleared", {28'b0, m_zc}, 32'd0);
                checkOutput("oc_cleared", {28'b0, m_oc}, 32'd0);
            end
            if (m >= len) begin
                checkOutput("signature", m_sig, esig);
                checkOutput("zero_count", {28'b0, m_zc}, 32'(ezc));
                checkOutput("ovf_count", {28'b0, m_oc}, 32'(eoc));
            end
            if (n != last) begin
                @(posedge clk);
                #1;
            end
        end
        start_req = 1'b0;
        checkOutput("done_pulses", 32'(dones), 32'(nsweeps));
        @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'b0, m_busy}, 32'd0);
        checkOutput("idle_done", {31'b0, m_done}, 32'd0);
        checkOutput("idle_sig_hold", m_sig, esig);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy_a}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done_a}, 32'd0);
        checkOutput({tag, "_op"}, {28'b0, op_a}, 32'd0);
        checkOutput({tag, "_x"}, ax_a, 32'd0);
        checkOutput({tag, "_y"}, ay_a, 32'd0);
        checkOutput({tag, "_sig"}, sig_a, SEED);
        checkOutput({tag, "_zc"}, {28'b0, zc_a}, 32'd0);
        checkOutput({tag, "_oc"}, {28'b0, oc_a}, 32'd0);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] held_sig;
        #12;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1);
        applyStimulus(32'h44906a28, 32'h44906a28, 1'b0, 1'b0, 1);
        applyStimulus(32'h1, 32'h2, 1'b1, 1'b0, 1);
        applyStimulus(32'h5, 32'h9, 1'b0, 1'b1, 2);

        // Reset in the middle of the op=3 window, then an uninterrupted rerun.
        @(negedge clk);
        sel       = 1'b0;
        x_in      = 32'h3;
        y_in      = 32'h3;
        start_req = 1'b1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre_reset_op", {28'b0, op_a}, 32'd3);
        rst = 1'b1;
        #1;
        checkReset("midreset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h3, 32'h3, 1'b0, 1'b0, 1);

        // Back-to-back sweeps with a hold window between them.
        applyStimulus(32'hffffffff, 32'h7fffffff, 1'b0, 1'b0, 1);
        held_sig = sig_a;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("sig_stable", sig_a, held_sig);
        end
        applyStimulus(32'h1, 32'hffffffff, 1'b0, 1'b0, 1);

        for (int i = 0; i < 6; i++) begin
            rx = (i % 2 == 0) ? 32'($urandom_range(0, 12)) : $urandom;
            ry = (i % 3 == 0) ? rx : $urandom;
            applyStimulus(rx, ry, (i % 3 == 2), 1'b0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
